// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic light phase scheduler.
// Tick-driven ring with pedestrian truncation and emergency override.
module traffic_phase_scheduler #(
    parameter int G_A_T      = 20,
    parameter int G_B_T      = 30,
    parameter int Y_T        = 3,
    parameter int AR_T       = 1,
    parameter int PED_REMAIN = 4,
    parameter int TW         = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          ped_req_a,
    input  logic          ped_req_b,
    input  logic          emg_a,
    input  logic          emg_b,
    output logic [2:0]    led_a,
    output logic [2:0]    led_b,
    output logic [2:0]    phase,
    output logic [TW-1:0] time_left,
    output logic          ped_pend_a,
    output logic          ped_pend_b
);

    typedef enum logic [2:0] {
        G_A  = 3'd0,
        Y_A  = 3'd1,
        R_A  = 3'd2,
        G_B  = 3'd3,
        Y_B  = 3'd4,
        R_B  = 3'd5,
        BAD6 = 3'd6,
        BAD7 = 3'd7
    } phase_t;

    localparam logic [TW-1:0] LD_GA  = TW'(G_A_T - 1);
    localparam logic [TW-1:0] LD_GB  = TW'(G_B_T - 1);
    localparam logic [TW-1:0] LD_Y   = TW'(Y_T - 1);
    localparam logic [TW-1:0] LD_AR  = TW'(AR_T - 1);
    localparam logic [TW-1:0] LD_PED = TW'(PED_REMAIN);

    phase_t        state, state_nxt;
    logic [TW-1:0] cnt, cnt_nxt;
    logic          pend_a_nxt, pend_b_nxt;
    logic          emg_eff_a, emg_eff_b, hold;
    logic          enter_a, enter_b;

    // Emergency arbitration: road A wins when both are asserted.
    always_comb begin
        emg_eff_a = emg_a;
        emg_eff_b = emg_b && !emg_a;
        hold      = (emg_eff_a && state == G_A) ||
                    (emg_eff_b && state == G_B);
    end

    // Next phase and countdown, evaluated in priority order on a tick.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (tick) begin
            if (state == BAD6 || state == BAD7) begin
                state_nxt = G_A;
                cnt_nxt   = LD_GA;
            end else if (hold) begin
                cnt_nxt = cnt;
            end else if (emg_eff_a && state == G_B) begin
                state_nxt = Y_B;
                cnt_nxt   = LD_Y;
            end else if (emg_eff_b && state == G_A) begin
                state_nxt = Y_A;
                cnt_nxt   = LD_Y;
            end else if (cnt == '0) begin
                unique case (state)
                    G_A:     begin state_nxt = Y_A; cnt_nxt = LD_Y;  end
                    Y_A:     begin state_nxt = R_A; cnt_nxt = LD_AR; end
                    R_A:     begin state_nxt = G_B; cnt_nxt = LD_GB; end
                    G_B:     begin state_nxt = Y_B; cnt_nxt = LD_Y;  end
                    Y_B:     begin state_nxt = R_B; cnt_nxt = LD_AR; end
                    default: begin state_nxt = G_A; cnt_nxt = LD_GA; end
                endcase
            end else if (ped_pend_b && state == G_A && cnt > LD_PED) begin
                cnt_nxt = LD_PED;
            end else if (ped_pend_a && state == G_B && cnt > LD_PED) begin
                cnt_nxt = LD_PED;
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    // Request latches: entering the served green clears, beating a new set.
    always_comb begin
        enter_a    = (state_nxt == G_A) && (state != G_A);
        enter_b    = (state_nxt == G_B) && (state != G_B);
        pend_a_nxt = enter_a ? 1'b0
                   : (ped_pend_a || (ped_req_a && state != G_A));
        pend_b_nxt = enter_b ? 1'b0
                   : (ped_pend_b || (ped_req_b && state != G_B));
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= G_A;
            cnt        <= LD_GA;
            ped_pend_a <= 1'b0;
            ped_pend_b <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ped_pend_a <= pend_a_nxt;
            ped_pend_b <= pend_b_nxt;
        end
    end

    // Lamp decode straight from the phase register.
    always_comb begin
        led_a = 3'b100;
        led_b = 3'b100;
        unique case (state)
            G_A:     led_a = 3'b001;
            Y_A:     led_a = 3'b010;
            G_B:     led_b = 3'b001;
            Y_B:     led_b = 3'b010;
            default: begin
                led_a = 3'b100;
                led_b = 3'b100;
            end
        endcase
    end

    assign phase     = state;
    assign time_left = cnt;

endmodule
